exec_mem_stage: RTL and testbench
=================================

# exec_mem_stage

Execute and memory stage of the single-cycle RV32 datapath. It decodes the ALU operation from the main-control `aluop` and the instruction funct fields, and computes the 32-bit ALU result with zero and overflow flags. It then uses the low result bits to address a 256-word data memory. It sits between the register-file/immediate operand mux and the write-back mux.

## Interface
Parameters:
- `DATA_W`, 32: datapath width.
- `ADDR_W`, 10: byte address width into data memory; depth = 2^(ADDR_W-2) words.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `aluop`  in  2  class from main control.
- `funct7`  in  7  instruction[31:25].
- `funct3`  in  3  instruction[14:12].
- `a`  in  32  operand 1 (rs1 data).
- `b`  in  32  operand 2 (rs2 data or immediate, already muxed).
- `store_data`  in  32  rs2 data for stores.
- `memread`  in  1  enables `readdata`.
- `memwrite`  in  1  store enable.
- `aluctl`  out  4  decoded ALU control, exported for debug.
- `alu_result`  out  32  ALU result; its low `ADDR_W` bits form the memory address.
- `zero`  out  1  high when `alu_result` == 0.
- `overflow`  out  1  signed overflow of ADD or SUB.
- `readdata`  out  32  memory read data.

## Operation
- ALU control is combinational.
  - `aluop`=00 gives ADD (0010), for load/store address.
  - `aluop`=01 gives SUB (0110), for branch compare.
  - `aluop`=10 (R-type) decodes by funct3:
    - 000 gives ADD, or SUB if `funct7`=0100000.
    - 111 gives AND (0000); 110 gives OR (0001); 010 gives SLT (0111).
    - Anything else gives ADD.
  - `aluop`=11 (I-type ALU) decodes funct3 the same way but ignores funct7, so 000 is always ADD.
- ALU operations, combinational:
  - 0000 AND; 0001 OR; 0010 a+b; 0110 a-b; 1100 NOR.
  - 0111 SLT: signed compare, result 1 or 0.
  - Any other code gives result 0.
- `overflow`:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from `a`.
  - 0 for every other operation.
- `zero` is evaluated on the final `alu_result`.
- Data memory:
  - 256 x 32-bit words, word index = `alu_result[9:2]`.
  - `alu_result[1:0]` are ignored; misaligned accesses are treated as aligned.
- Read is combinational: `readdata` = mem[index] when `memread`=1, else 32'h0.
- Write happens at the rising `clk` edge when `memwrite`=1 and `rst_n`=1: mem[index] <= `store_data`.
- Reset: `rst_n` low clears every memory word to 0 immediately and suppresses writes. `readdata` therefore reads 0 during reset.
- Outputs have no reset values of their own; they follow inputs combinationally.

## Timing
- ALU control, ALU and memory read: zero latency, all within one cycle.
- Store: one cycle. Data is visible on `readdata` combinationally just after the capturing edge.
- Simultaneous `memread` and `memwrite`:
  - Before the edge, `readdata` shows the old word.
  - After the edge, it shows the new word.
- Reset mid-operation:
  - A store whose edge coincides with `rst_n` low is discarded.
  - Memory stays zero until the first edge after `rst_n` rises.
- Address wrap: bits above `ADDR_W` of `alu_result` are ignored, so address 0x400 aliases 0x000.

## Structure
- Shared package `exec_pkg`:
  - ALU control localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - aluop encodings.
  - funct3/funct7 constants.
- Sub-modules:
  - `exec_alu_ctl`: combinational decoder.
  - `exec_alu`: combinational ALU with flags.
  - `exec_dmem`: memory array with reset and write logic.
- The top only wires them, driving the memory address from the low `ADDR_W` bits of `alu_result`.

## Test plan
- R-type, `aluop`=10, funct3=000:
  - funct7=0000000, a=5, b=7 -> `aluctl`=0010, result 12, zero=0.
  - funct7=0100000, a=7, b=7 -> `aluctl`=0110, result 0, zero=1.
- Overflow:
  - ADD 32'h7FFFFFFF+1 -> result 32'h80000000, overflow=1.
  - SUB 32'h80000000-1 -> overflow=1.
  - AND with the same operands -> overflow=0.
- AND/OR/SLT:
  - a=32'hF0F0_0000, b=32'h0FF0_0000 -> AND 32'h00F0_0000, OR 32'hFFF0_0000.
  - SLT with a=-1, b=1 -> result 1.
- Store then load, `aluop`=00:
  - Store, a=0, b=8, store_data=32'hDEADBEEF, memwrite=1 for one edge.
  - Then load with memread=1 at address 8 -> readdata=32'hDEADBEEF.
  - Address 9 -> same word; memread=0 -> readdata=0.
- Reset: write word 4, assert `rst_n`=0 asynchronously mid-cycle -> readdata at address 4 goes 0 without a clock edge; a store attempted during reset leaves memory 0.
- `aluop`=11, funct3=000, funct7=0100000, a=3, b=4 -> ADD, result 7 (funct7 ignored).

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants for the execute/memory stage: ALU control codes,
// main-control aluop classes and the instruction funct encodings they decode.
package exec_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU with zero and signed-overflow flags.
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]        ctl_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign lt   = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (ctl_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = DATA_W'(lt);
            ALU_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/exec_alu_ctl.sv
// ALU control decoder: maps the main-control aluop class plus funct fields
// onto a 4-bit ALU operation code.
module exec_alu_ctl
    import exec_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [3:0] aluctl_o
);

    logic [3:0] f3_ctl;

    always_comb begin
        f3_ctl   = ALU_ADD;
        aluctl_o = ALU_ADD;

        case (funct3_i)
            F3_AND:  f3_ctl = ALU_AND;
            F3_OR:   f3_ctl = ALU_OR;
            F3_SLT:  f3_ctl = ALU_SLT;
            default: f3_ctl = ALU_ADD;
        endcase

        // Only R-type honours funct7; I-type immediates occupy those bits.
        case (aluop_i)
            ALUOP_LDST: aluctl_o = ALU_ADD;
            ALUOP_BR:   aluctl_o = ALU_SUB;
            ALUOP_R:    aluctl_o = (funct3_i == F3_ADDSUB && funct7_i == F7_SUB) ? ALU_SUB : f3_ctl;
            default:    aluctl_o = f3_ctl;
        endcase
    end

endmodule

// File: rtl/exec_dmem.sv
// Word-addressed data memory: combinational read, clocked write,
// asynchronous clear of every word while rst_n is low.
module exec_dmem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              unused_addr_lsb;

    // Byte offset is dropped: misaligned accesses hit the containing word.
    assign idx             = addr_i[ADDR_W-1:2];
    assign unused_addr_lsb = ^addr_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memwrite_i) begin
            mem_q[idx] <= wdata_i;
        end
    end

    assign rdata_o = memread_i ? mem_q[idx] : '0;

endmodule

// File: rtl/exec_mem_stage.sv
// Execute + memory stage of the single-cycle RV32 datapath: ALU control,
// ALU, and data memory addressed by the low ADDR_W bits of the ALU result.
module exec_mem_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        aluop,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] store_data,
    input  logic              memread,
    input  logic              memwrite,
    output logic [3:0]        aluctl,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              overflow,
    output logic [DATA_W-1:0] readdata
);

    exec_alu_ctl u_alu_ctl (
        .aluop_i  (aluop),
        .funct7_i (funct7),
        .funct3_i (funct3),
        .aluctl_o (aluctl)
    );

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .ctl_i      (aluctl),
        .a_i        (a),
        .b_i        (b),
        .result_o   (alu_result),
        .zero_o     (zero),
        .overflow_o (overflow)
    );

    exec_dmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dmem (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (alu_result[ADDR_W-1:0]),
        .wdata_i    (store_data),
        .memread_i  (memread),
        .memwrite_i (memwrite),
        .rdata_o    (readdata)
    );

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage: a behavioural model checked every
// negative edge, plus literal expectations from hand-worked vectors.
module tb_exec_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  aluop;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] a, b, store_data;
    logic        memread, memwrite;
    logic [3:0]  aluctl;
    logic [31:0] alu_result;
    logic        zero, overflow;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [256];

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    exec_mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .aluop      (aluop),
        .funct7     (funct7),
        .funct3     (funct3),
        .a          (a),
        .b          (b),
        .store_data (store_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .aluctl     (aluctl),
        .alu_result (alu_result),
        .zero       (zero),
        .overflow   (overflow),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_ctl(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] byf3;
        case (f3)
            3'b111:  byf3 = 4'b0000;
            3'b110:  byf3 = 4'b0001;
            3'b010:  byf3 = 4'b0111;
            default: byf3 = 4'b0010;
        endcase
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b10 && f3 == 3'b000 && f7 == 7'b0100000) return 4'b0110;
        return byf3;
    endfunction

    function automatic logic [31:0] m_res(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return 32'(sx + sy);
            4'b0110: return 32'(sx - sy);
            4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ovf(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        if (c == 4'b0010)      r = sx + sy;
        else if (c == 4'b0110) r = sx - sy;
        else return 1'b0;
        return (r > SMAX) || (r < SMIN);
    endfunction

    function automatic logic [7:0] m_idx();
        logic [31:0] r = m_res(m_ctl(aluop, funct7, funct3), a, b);
        return 8'((r % 1024) / 4);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model-based check of every output on each falling edge.
    always @(negedge clk) begin
        logic [3:0]  ec;
        logic [31:0] er;
        ec = m_ctl(aluop, funct7, funct3);
        er = m_res(ec, a, b);
        cmp("model_aluctl", 32'(aluctl), 32'(ec));
        cmp("model_result", alu_result, er);
        cmp("model_zero", 32'(zero), 32'(er == 32'd0));
        cmp("model_overflow", 32'(overflow), 32'(m_ovf(ec, a, b)));
        cmp("model_readdata", readdata, memread ? mem_m[m_idx()] : 32'd0);
    end

    // Advance one edge (committing any pending store in the model), then apply a new vector.
    task automatic vec(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] av, input logic [31:0] bv, input logic [31:0] sd,
                       input logic mr, input logic mw);
        @(posedge clk);
        if (rst_n && memwrite) mem_m[m_idx()] = store_data;
        #1;
        aluop = op; funct7 = f7; funct3 = f3;
        a = av; b = bv; store_data = sd;
        memread = mr; memwrite = mw;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
        rst_n = 1'b0;
        aluop = 2'b00; funct7 = 7'd0; funct3 = 3'd0;
        a = 32'd0; b = 32'd0; store_data = 32'd0;
        memread = 1'b1; memwrite = 1'b0;
        #2;
        cmp("reset_readdata", readdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // R-type add / sub
        vec(2'b10, 7'b0000000, 3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("radd_ctl", 32'(aluctl), 32'h2);
        cmp("radd_res", alu_result, 32'd12);
        cmp("radd_zero", 32'(zero), 32'd0);
        vec(2'b10, 7'b0100000, 3'b000, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("rsub_ctl", 32'(aluctl), 32'h6);
        cmp("rsub_res", alu_result, 32'd0);
        cmp("rsub_zero", 32'(zero), 32'd1);

        // Overflow cases
        vec(2'b00, 7'd0, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("add_ovf_res", alu_result, 32'h8000_0000);
        cmp("add_ovf", 32'(overflow), 32'd1);
        vec(2'b01, 7'd0, 3'd0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("sub_ovf", 32'(overflow), 32'd1);
        cmp("sub_ovf_res", alu_result, 32'h7FFF_FFFF);
        vec(2'b10, 7'd0, 3'b111, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("and_no_ovf", 32'(overflow), 32'd0);

        // AND / OR / SLT
        vec(2'b10, 7'd0, 3'b111, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("and_res", alu_result, 32'h00F0_0000);
        vec(2'b11, 7'd0, 3'b110, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("or_res", alu_result, 32'hFFF0_0000);
        vec(2'b10, 7'd0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("slt_res", alu_result, 32'd1);
        vec(2'b10, 7'd0, 3'b010, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("slt_res_rev", alu_result, 32'd0);
        vec(2'b10, 7'd0, 3'b101, 32'd9, 32'd6, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("f3_default_add", alu_result, 32'd15);

        // I-type ignores funct7
        vec(2'b11, 7'b0100000, 3'b000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("itype_ctl", 32'(aluctl), 32'h2);
        cmp("itype_res", alu_result, 32'd7);

        // Store then load, misaligned alias, memread gating
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd8, 32'hDEAD_BEEF, 1'b0, 1'b1);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd8, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("load8", readdata, 32'hDEAD_BEEF);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd9, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("load9", readdata, 32'hDEAD_BEEF);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd9, 32'd0, 1'b0, 1'b0);
        mid();
        cmp("load_noread", readdata, 32'd0);

        // Simultaneous read/write: old word before edge, new word after
        vec(2'b00, 7'd0, 3'd0, 32'd4, 32'd4, 32'h1234_5678, 1'b1, 1'b1);
        mid();
        cmp("rw_before", readdata, 32'hDEAD_BEEF);
        vec(2'b00, 7'd0, 3'd0, 32'd4, 32'd4, 32'd0, 1'b1, 1'b0);
        cmp("rw_after", readdata, 32'h1234_5678);

        // Address wrap: 0x404 aliases 0x004
        vec(2'b00, 7'd0, 3'd0, 32'h400, 32'd4, 32'hCAFE_F00D, 1'b0, 1'b1);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("wrap_alias", readdata, 32'hCAFE_F00D);

        // Async reset mid-cycle clears memory without an edge
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd16, 32'hA5A5_5A5A, 1'b0, 1'b1);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd16, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("pre_reset_word4", readdata, 32'hA5A5_5A5A);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
        #1;
        cmp("async_reset_word4", readdata, 32'd0);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd16, 32'h5555_AAAA, 1'b1, 1'b1);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd16, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("store_in_reset", readdata, 32'd0);
        rst_n = 1'b1;
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'd8, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("after_reset_word2", readdata, 32'd0);

        // Store after reset release takes effect again
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'h3FC, 32'h0BAD_F00D, 1'b1, 1'b1);
        vec(2'b00, 7'd0, 3'd0, 32'd0, 32'h3FC, 32'd0, 1'b1, 1'b0);
        mid();
        cmp("top_word_store", readdata, 32'h0BAD_F00D);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
